// File: rtl/reset_sequencer.sv
// ----------------------------------------------------------------------------
// reset_sequencer
//   Power-on / user reset sequencer for MiST cores. Holds the core in reset
//   until the PLL is locked, every required ioctl image has been downloaded and
//   a hold time has elapsed, then releases NUM_OUT reset outputs one at a time
//   with a fixed gap (SDRAM controller first, then CPU, then peripherals).
//
// Ports
//   clk_sys        in  1        system clock
//   reset          in  1        asynchronous active-high master reset
//   pll_locked     in  1        asynchronous PLL lock (synchronised here)
//   btn_reset      in  1        asynchronous reset button (synchronised here)
//   sw_reset       in  1        OSD reset request, clk_sys domain
//   ioctl_download in  1        data_io download active, clk_sys domain
//   ioctl_index    in  8        data_io image index
//   rst_out        out NUM_OUT  staged resets, active-high, bit 0 released first
//   loaded         out 8        sticky download-complete flags, indices 0..7
//   ready          out 1        high once every stage has been released
// ----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLD        = 16'hffff,
  parameter int unsigned NUM_OUT     = 2,
  parameter int unsigned STAGE_GAP   = 256,
  parameter logic [7:0]  REQ_MASK    = 8'h01,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               btn_reset,
  input  logic               sw_reset,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [7:0]         loaded,
  output logic               ready
);

  // Stage index must be able to count up to NUM_OUT (max 8).
  localparam int unsigned STG_W = 4;

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(STAGE_GAP);

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_STAGE = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronisers; both reset to 0 so a fresh reset looks like "no lock".
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic [SYNC_STAGES-1:0] r_pll_sync;
  logic                   w_btn_s;
  logic                   w_pll_s;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_btn_sync <= '0;
      r_pll_sync <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], btn_reset};
      r_pll_sync <= {r_pll_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_btn_s = r_btn_sync[SYNC_STAGES-1];
  assign w_pll_s = r_pll_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Download tracking: a falling edge of ioctl_download marks its index loaded.
  // Indices 8 and above are outside the flag vector and are ignored.
  // --------------------------------------------------------------------------
  logic       r_dl;
  logic       w_idx_ok;
  logic [2:0] w_idx;
  logic       w_dl_req;
  logic       w_dl_done;

  assign w_idx_ok  = (ioctl_index[7:3] == 5'd0);
  assign w_idx     = ioctl_index[2:0];
  assign w_dl_req  = ioctl_download & w_idx_ok & REQ_MASK[w_idx];
  assign w_dl_done = r_dl & ~ioctl_download & w_idx_ok;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl   <= 1'b0;
      loaded <= 8'd0;
    end else begin
      r_dl <= ioctl_download;
      if (w_dl_done) begin
        loaded <= loaded | (8'd1 << w_idx);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reset request and release gate.
  // --------------------------------------------------------------------------
  logic w_req;
  logic w_gate;

  assign w_req  = sw_reset | w_btn_s | ~w_pll_s | w_dl_req;
  assign w_gate = ((loaded & REQ_MASK) == REQ_MASK);

  // --------------------------------------------------------------------------
  // Sequencer state.
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_gap;
  logic [STG_W-1:0]   r_stage;

  logic [1:0]         w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_gap_nxt;
  logic [STG_W-1:0]   w_stage_nxt;
  logic [NUM_OUT-1:0] w_rst_nxt;
  logic               w_ready_nxt;

  // Next-state and next-output logic; a reset request overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_stage_nxt = r_stage;
    w_rst_nxt   = rst_out;
    w_ready_nxt = ready;

    if (w_req) begin
      w_state_nxt = S_WAIT;
      w_cnt_nxt   = HOLD_C;
      w_rst_nxt   = '1;
      w_ready_nxt = 1'b0;
      w_stage_nxt = '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_gate) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_C;
          end
        end

        S_HOLD: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_rst_nxt[0] = 1'b0;
            w_stage_nxt  = STG_W'(1);
            w_gap_nxt    = GAP_C;
            if (NUM_OUT == 1) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else begin
              w_state_nxt = S_STAGE;
            end
          end
        end

        S_STAGE: begin
          if (r_gap != '0) begin
            w_gap_nxt = r_gap - CNT_W'(1);
          end else begin
            // Release the output addressed by the current stage index.
            for (int i = 0; i < int'(NUM_OUT); i++) begin
              if (STG_W'(i) == r_stage) begin
                w_rst_nxt[i] = 1'b0;
              end
            end
            w_stage_nxt = r_stage + STG_W'(1);
            w_gap_nxt   = GAP_C;
            if (r_stage == STG_W'(NUM_OUT - 1)) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end
          end
        end

        S_RUN: begin
          w_state_nxt = S_RUN;
        end

        default: begin
          w_state_nxt = S_WAIT;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_cnt   <= HOLD_C;
      r_gap   <= '0;
      r_stage <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_stage <= w_stage_nxt;
      rst_out <= w_rst_nxt;
      ready   <= w_ready_nxt;
    end
  end

endmodule
